// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
// LSU_PROTECT_EN enables the store address protection check.
package lsu_pkg;

  localparam int unsigned LsuAw       = 8;
  localparam int unsigned LsuDw       = 8;
  localparam logic [7:0]  LsuProtBase = 8'hF0;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/lsu_prot_check.sv
// Flags a store that touches any byte at or above PROT_BASE.
// Only instantiated when LSU_PROTECT_EN is defined.
module lsu_prot_check #(
  parameter int unsigned   AW        = 8,
  parameter logic [AW-1:0] PROT_BASE = '1
) (
  input  logic [AW-1:0] addr_i,
  input  logic          wide_i,
  input  logic          we_i,
  output logic          err_o
);

  logic [AW-1:0] addr_hi;

  // The high byte of a wide access wraps at the top of memory.
  assign addr_hi = addr_i + AW'(1);
  assign err_o   = we_i && ((addr_i >= PROT_BASE) || (wide_i && (addr_hi >= PROT_BASE)));

endmodule

// File: rtl/load_store_unit.sv
// Sequences 8/16-bit little-endian loads and stores onto a single-port byte memory.
// Define LSU_PROTECT_EN to reject stores into the protected region.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned   AW        = LsuAw,
  parameter int unsigned   DW        = LsuDw,
  parameter logic [AW-1:0] PROT_BASE = AW'(LsuProtBase)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic            req_wide_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [2*DW-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [2*DW-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic            mem_we_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic            wide_q, wide_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2*DW-1:0] wdata_q, wdata_d;
  logic [2*DW-1:0] rdata_q, rdata_d;
  logic            err_q;
  logic            accept;

  assign req_ready_o = (state_q == StIdle) || ((state_q == StResp) && rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

`ifdef LSU_PROTECT_EN
  logic prot_err;

  lsu_prot_check #(
    .AW       (AW),
    .PROT_BASE(PROT_BASE)
  ) u_prot_check (
    .addr_i(req_addr_i),
    .wide_i(req_wide_i),
    .we_i  (req_we_i),
    .err_o (prot_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= prot_err;
    end
  end
`else
  logic unused_prot_base;

  assign err_q            = 1'b0;
  assign unused_prot_base = ^PROT_BASE;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    wide_d  = wide_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StLo: begin
        if (!we_q) rdata_d[DW-1:0] = mem_rdata_i;
        state_d = wide_q ? StHi : StResp;
      end
      StHi: begin
        if (!we_q) rdata_d[2*DW-1:DW] = mem_rdata_i;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Acceptance is only possible from Idle or a consumed Resp.
    if (accept) begin
      we_d    = req_we_i;
      wide_d  = req_wide_i;
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
      rdata_d = '0;
      state_d = StLo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      wide_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wide_q  <= wide_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Write enable is masked by reset so an interrupted wide store leaves its high byte alone.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    unique case (state_q)
      StLo: begin
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q[DW-1:0];
        mem_we_o    = we_q && !err_q && !reset;
      end
      StHi: begin
        mem_addr_o  = addr_q + AW'(1);
        mem_wdata_o = wdata_q[2*DW-1:DW];
        mem_we_o    = we_q && !err_q && !reset;
      end
      default: begin
        mem_we_o = 1'b0;
      end
    endcase
  end

  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, corner sequences, random traffic
// checked against a transaction-level memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_wide;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_wide_i (req_wide),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_we_o   (mem_we),
    .mem_rdata_i(mem_rdata)
  );

`ifdef LSU_PROTECT_EN
  localparam bit ProtEn = 1'b1;
`else
  localparam bit ProtEn = 1'b0;
`endif

  // Byte memory with combinational read, plus a log of every write the DUT performs.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] wr_addr_log [1024];
  logic [7:0] wr_data_log [1024];
  int         wr_cyc_log  [1024];
  int         wr_n = 0;
  int         cyc = 0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (wr_n < 1024) begin
        wr_addr_log[wr_n] <= mem_addr;
        wr_data_log[wr_n] <= mem_wdata;
        wr_cyc_log[wr_n]  <= cyc;
        wr_n              <= wr_n + 1;
      end
    end
  end

  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input bit we, input bit wide, input logic [7:0] addr);
    logic [7:0] a1;
    a1 = addr + 8'd1;
    return ProtEn && we && ((addr >= 8'hF0) || (wide && (a1 >= 8'hF0)));
  endfunction

  task automatic run_txn(input bit we, input bit wide, input logic [7:0] addr,
                         input logic [15:0] wd, input int hold, output logic [15:0] rd,
                         output logic err, output int lat, output bit stable);
    int w;
    rd = '0; err = 1'b0; lat = 0; stable = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_wide = wide; req_addr = addr; req_wdata = wd;
    rsp_ready = (hold == 0);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    err = rsp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== err || req_ready) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string tag, input bit we, input bit wide, input logic [7:0] addr,
                       input logic [15:0] wd, input int hold, output logic [15:0] rd,
                       output logic err);
    logic [7:0]  a1;
    logic        exp_err;
    logic [15:0] exp_rd;
    int          start, lat, n_exp;
    bit          stable;
    a1      = addr + 8'd1;
    exp_err = model_err(we, wide, addr);
    exp_rd  = we ? 16'h0000 : {(wide ? ref_mem[a1] : 8'h00), ref_mem[addr]};
    n_exp   = (we && !exp_err) ? (wide ? 2 : 1) : 0;
    start   = wr_n;
    run_txn(we, wide, addr, wd, hold, rd, err, lat, stable);
    check({tag, "_rdata"}, {16'd0, rd}, {16'd0, exp_rd});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_latency"}, lat, wide ? 3 : 2);
    if (hold > 0) check({tag, "_hold_stable"}, {31'd0, stable}, 32'd1);
    check({tag, "_n_writes"}, wr_n - start, n_exp);
    if (n_exp >= 1) begin
      check({tag, "_wr_lo_addr"}, {24'd0, wr_addr_log[start]}, {24'd0, addr});
      check({tag, "_wr_lo_data"}, {24'd0, wr_data_log[start]}, {24'd0, wd[7:0]});
      ref_mem[addr] = wd[7:0];
    end
    if (n_exp == 2) begin
      check({tag, "_wr_hi_addr"}, {24'd0, wr_addr_log[start+1]}, {24'd0, a1});
      check({tag, "_wr_hi_data"}, {24'd0, wr_data_log[start+1]}, {24'd0, wd[15:8]});
      check({tag, "_wr_consecutive"}, wr_cyc_log[start+1] - wr_cyc_log[start], 1);
      ref_mem[a1] = wd[15:8];
    end
  endtask

  typedef struct {
    bit          we;
    bit          wide;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [15:0] rd;
    logic        err;
    logic [7:0]  pre31, ra;
    int          start, diffs, sel;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wide = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    vecs.push_back('{1'b1, 1'b0, 8'h10, 16'h00A5, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h20, 16'h0000, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h21, 16'h0000, 16'h00BE, 1'b0});
`ifdef LSU_PROTECT_EN
    vecs.push_back('{1'b1, 1'b1, 8'hEF, 16'h5566, 16'h0000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'hEF, 16'h0077, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'hF5, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'hEF, 16'h0000, 16'h0077, 1'b0});
`else
    vecs.push_back('{1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0012, 1'b0});
`endif

    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check("reset_mem_addr", {24'd0, mem_addr}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply("vec", vecs[i].we, vecs[i].wide, vecs[i].addr, vecs[i].wdata, 0, rd, err);
      check("vec_table_rdata", {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
      check("vec_table_err", {31'd0, err}, {31'd0, vecs[i].exp_err});
    end

    // Backpressure: response held for 5 cycles while another request waits.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b0; req_addr = 8'h10; rsp_ready = 1'b0;
    @(negedge clk);
    req_wide = 1'b1; req_addr = 8'h20;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", {16'd0, rsp_rdata}, 32'h00A5);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_same_cycle_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_next_lo_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_next_lo_addr", {24'd0, mem_addr}, 32'h20);
    @(negedge clk);
    check("bp_hi_addr", {24'd0, mem_addr}, 32'h21);
    @(negedge clk);
    check("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_second_rdata", {16'd0, rsp_rdata}, 32'hBEEF);
    @(posedge clk);
    #1;

    // Reset during the high byte of a wide store.
    pre31 = ref_mem[8'h31];
    start = wr_n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_wide = 1'b1; req_addr = 8'h30; req_wdata = 16'hCAFE;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_lo_we", {31'd0, mem_we}, 32'd1);
    check("rst_lo_addr", {24'd0, mem_addr}, 32'h30);
    @(negedge clk);
    check("rst_hi_addr", {24'd0, mem_addr}, 32'h31);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mem30", {24'd0, mem[8'h30]}, 32'hFE);
    check("rst_mem31", {24'd0, mem[8'h31]}, {24'd0, pre31});
    check("rst_n_writes", wr_n - start, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("rst_no_late_rsp", {31'd0, rsp_valid}, 32'd0);
    ref_mem[8'h30] = 8'hFE;

    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(3, 0));
      case (sel)
        0: ra = 8'($urandom);
        1: ra = 8'hFF;
        2: ra = 8'hEC + 8'($urandom_range(7, 0));
        default: ra = 8'($urandom_range(15, 0));
      endcase
      apply("rand", 1'($urandom), 1'($urandom), ra, 16'($urandom),
            int'($urandom_range(3, 0)), rd, err);
    end

    diffs = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) diffs++;
    check("final_mem_image_diffs", diffs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
